// File: rtl/scan_chain_sequencer.sv
// Scan chain sequencer: one refresh writes a cell's inputs
// and reads that cell's outputs back from the chain return.
module scan_chain_sequencer #(
  parameter int NUM_DESIGNS = 25,
  parameter int NUM_IOS     = 8,
  parameter int SEL_WIDTH   = 9,
  parameter int HALF_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] active_select,
  input  logic [NUM_IOS-1:0]   inputs,
  output logic [NUM_IOS-1:0]   outputs,
  output logic                 ready,
  output logic                 busy,
  output logic                 scan_clk_out,
  output logic                 scan_data_out,
  output logic                 scan_select,
  output logic                 scan_latch_en,
  input  logic                 scan_data_in
);

  localparam int N  = NUM_DESIGNS * NUM_IOS;
  localparam int H  = HALF_PERIOD;
  localparam int PW = $clog2(2 * H);
  localparam int NW = $clog2(N + 1);
  localparam int IW = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
  localparam int AW = SEL_WIDTH + IW;
  localparam int CW = ((AW > NW) ? AW : NW) + 1;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, SHIFT, LATCH, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [NW-1:0]        n_q, n_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_IOS-1:0]   in_q, in_d;
  logic [NUM_IOS-1:0]   shadow_q, shadow_d;
  logic [NUM_IOS-1:0]   out_q, out_d;
  logic                 data_q, data_d;

  logic [CW-1:0]        base;
  logic [CW-1:0]        pos;
  logic [IW-1:0]        off;
  logic                 hit;
  logic                 drive;
  logic                 pulse_end;

  // Chain position of the current shift index relative to the target cell
  assign base  = CW'(sel_q) * CW'(NUM_IOS);
  assign pos   = CW'(N - 1) - CW'(n_q);
  assign hit   = (pos >= base) && (pos < base + CW'(NUM_IOS));
  assign off   = IW'(pos - base);
  assign drive = hit & in_q[off];

  assign pulse_end = (cnt_q == PW'(2 * H - 1));

  assign outputs       = out_q;
  assign ready         = (state_q == DONE);
  assign busy          = (state_q == CAPTURE) ||
                         (state_q == SHIFT) ||
                         (state_q == LATCH);
  assign scan_clk_out  = ((state_q == CAPTURE) ||
                          (state_q == SHIFT)) &&
                         (cnt_q >= PW'(H));
  assign scan_select   = (state_q == CAPTURE);
  assign scan_latch_en = (state_q == LATCH) &&
                         (cnt_q < PW'(H));
  assign scan_data_out = ((state_q == SHIFT) &&
                          (cnt_q == '0)) ? drive : data_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      sel_q    <= '0;
      in_q     <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      sel_q    <= sel_d;
      in_q     <= in_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      data_q   <= data_d;
    end
  end

  // Next-state sequencing of capture, shift, latch and done
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    sel_d    = sel_q;
    in_d     = in_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = active_select;
          in_d     = inputs;
          shadow_d = '0;
          cnt_d    = '0;
          n_d      = '0;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d = cnt_q + PW'(1);
        if (pulse_end) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0)
          data_d = drive;
        if ((cnt_q == PW'(H - 1)) && hit)
          shadow_d[off] = scan_data_in;
        cnt_d = cnt_q + PW'(1);
        if (pulse_end) begin
          cnt_d = '0;
          if (n_q == NW'(N - 1)) begin
            n_d     = '0;
            state_d = LATCH;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + PW'(1);
        if (pulse_end) begin
          cnt_d   = '0;
          out_d   = shadow_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Bench for scan_chain_sequencer with a 4-cell chain model;
// cell 0 inverts its module inputs, the others loop back.
module tb_scan_chain_sequencer;

  localparam int ND  = 4;
  localparam int IOS = 8;
  localparam int SW  = 9;
  localparam int N   = ND * IOS;
  localparam int LAT = 2 * (N + 2) + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [SW-1:0] sel;
  logic [7:0]    din;
  logic [7:0]    outputs;
  logic          ready;
  logic          busy;
  logic          sclk;
  logic          sdo;
  logic          ssel;
  logic          le;
  logic          sdi;

  scan_chain_sequencer #(
    .NUM_DESIGNS(ND),
    .NUM_IOS(IOS),
    .SEL_WIDTH(SW),
    .HALF_PERIOD(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .active_select(sel),
    .inputs(din),
    .outputs(outputs),
    .ready(ready),
    .busy(busy),
    .scan_clk_out(sclk),
    .scan_data_out(sdo),
    .scan_select(ssel),
    .scan_latch_en(le),
    .scan_data_in(sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] sr = '0;
  logic         ret = 1'b0;
  logic [7:0]   mod_in [ND] = '{default: 8'h00};
  logic [7:0]   mo;
  logic         p_sclk = 1'b0;
  logic         p_ssel = 1'b0;
  logic         p_le = 1'b0;
  logic         p_sdo = 1'b0;
  logic         p_rst = 1'b1;
  int           rises = 0;
  int           latches = 0;
  int           readies = 0;
  int           ones = 0;
  int           viol = 0;

  assign sdi = ret;

  // Chain model and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sclk && !p_sclk) begin
      rises++;
      if (ssel) begin
        for (int k = 0; k < ND; k++) begin
          mo = (k == 0) ? ~mod_in[k] : mod_in[k];
          sr[k*IOS +: IOS] <= mo;
        end
      end else begin
        sr <= {sr[N-2:0], sdo};
      end
    end
    if (!sclk && p_sclk)
      ret <= sr[N-1];
    if (le && !p_le) begin
      latches++;
      for (int k = 0; k < ND; k++)
        mod_in[k] <= sr[k*IOS +: IOS];
    end
    if (ready) readies++;
    if (busy && sdo) ones++;
    if (sclk && p_sclk && (ssel != p_ssel || le != p_le))
      viol++;
    if (ssel && le) viol++;
    if (sdo != p_sdo && !(p_sclk && !sclk) && !p_rst)
      viol++;
    p_sclk <= sclk;
    p_ssel <= ssel;
    p_le   <= le;
    p_sdo  <= sdo;
    p_rst  <= reset;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    else
      passed++;
  endtask

  task automatic run(input logic [SW-1:0] s,
                     input logic [7:0] d,
                     output logic [7:0] got,
                     output int lat,
                     output int nr,
                     output logic b1);
    int r0;
    @(posedge clk); #1;
    sel = s; din = d; start = 1'b1; r0 = rises;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; b1 = busy;
    while (!ready && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    got = outputs;
    nr = rises - r0;
  endtask

  typedef struct {
    logic [SW-1:0] s;
    logic [7:0]    d;
    logic [7:0]    e;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    int lat, nr, o0, l0, r0, rd0;
    logic b1;

    tbl[0] = '{s: 9'd0, d: 8'hA5, e: 8'hFF};
    tbl[1] = '{s: 9'd0, d: 8'hFF, e: 8'h5A};
    tbl[2] = '{s: 9'd2, d: 8'h3C, e: 8'h00};
    tbl[3] = '{s: 9'd2, d: 8'h3C, e: 8'h3C};
    tbl[4] = '{s: 9'd7, d: 8'hFF, e: 8'h00};

    reset = 1'b1; start = 1'b1; sel = '0; din = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'(outputs), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scan", 32'({ready, sclk, sdo, ssel, le}), 0);
    chk("rst_rises", rises, 0);
    start = 1'b0; reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      o0 = ones;
      run(tbl[i].s, tbl[i].d, got, lat, nr, b1);
      chk($sformatf("v%0d_out", i), 32'(got), 32'(tbl[i].e));
      chk($sformatf("v%0d_lat", i), lat, LAT);
      chk($sformatf("v%0d_rises", i), nr, N + 1);
      chk($sformatf("v%0d_busy1", i), 32'(b1), 1);
      chk($sformatf("v%0d_done", i), 32'({ready, busy}), 2);
      if (i == 3) begin
        chk("cell1_in", 32'(mod_in[1]), 0);
        chk("cell3_in", 32'(mod_in[3]), 0);
        chk("cell2_in", 32'(mod_in[2]), 32'h3C);
      end
      if (i == 4)
        chk("oor_data", ones - o0, 0);
    end

    @(posedge clk); #1;
    sel = 9'd1; din = 8'h77; start = 1'b1; l0 = latches;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("mid_busy", 32'({busy, sclk}), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_scan", 32'({sclk, sdo, ssel, le}), 0);
    chk("mid_busy0", 32'({busy, ready}), 0);
    reset = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("mid_nolatch", latches - l0, 0);
    chk("mid_idle", 32'(busy), 0);
    run(9'd1, 8'h77, got, lat, nr, b1);
    chk("post_out1", 32'(got), 0);
    run(9'd1, 8'h77, got, lat, nr, b1);
    chk("post_out2", 32'(got), 32'h77);
    chk("post_lat", lat, LAT);

    @(posedge clk); #1;
    sel = 9'd1; din = 8'h11; start = 1'b1;
    r0 = rises; rd0 = readies;
    @(posedge clk); #1;
    lat = 1;
    while (!ready && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", lat, LAT);
    chk("hold_out", 32'(outputs), 32'h77);
    chk("hold_rises", rises - r0, N + 1);
    @(posedge clk); #1;
    chk("hold_idle", 32'(busy), 0);
    @(posedge clk); #1;
    chk("hold_relaunch", 32'(busy), 1);
    start = 1'b0; lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!ready && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold2_lat", lat, LAT);
    chk("hold2_out", 32'(outputs), 32'h11);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_readies", readies - rd0, 2);
    chk("hold_rises2", rises - r0, 2 * (N + 1));
    chk("hold_noqueue", 32'(busy), 0);
    chk("protocol", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
